pc_seq_unit: RTL and testbench

Parametrised program counter for the microprogrammed CPU. It replaces the fixed 8-bit PC with a configurable-width PC and adds the following:
- signed relative branch
- absolute load
- call/return with an internal return-address stack
- stall
- sticky stack-error flags

It sits between the control store sequencer and instruction memory address.

---
 rtl/pc_seq_unit.sv | 152 +++++++++++++++
 tb/tb_pc_seq_unit.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/pc_seq_unit.sv
// Program counter with relative branch, absolute load, call/return stack, stall and sticky stack-error flags.
// Optional breakpoint logic is compiled in when PC_BREAKPOINT_EN is defined.
module pc_seq_unit #(
  parameter int              PC_W      = 8,
  parameter int              OFF_W     = 8,
  parameter int              STK_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_VEC = '0
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_stall,
  input  logic                         i_pi,
  input  logic                         i_pl,
  input  logic                         i_pr,
  input  logic                         i_call,
  input  logic                         i_ret,
  input  logic                         i_flag_clr,
  input  logic [PC_W-1:0]              i_target,
  input  logic [OFF_W-1:0]             i_offset,
`ifdef PC_BREAKPOINT_EN
  input  logic [PC_W-1:0]              i_bp_addr,
  input  logic                         i_bp_en,
  input  logic                         i_bp_clr,
  output logic                         o_bp_hit,
`endif
  output logic [PC_W-1:0]              o_pc,
  output logic [$clog2(STK_DEPTH):0]   o_stk_cnt,
  output logic                         o_stk_full,
  output logic                         o_stk_empty,
  output logic                         o_ovf,
  output logic                         o_unf
);

  localparam int PTR_W = $clog2(STK_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [PC_W-1:0]  stk_q [STK_DEPTH];

  logic             push_en;
  logic             freeze;
  logic             stk_full, stk_empty;
  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  off_ext;
  logic [PTR_W-1:0] push_idx, top_idx;

  assign pc_inc    = pc_q + PC_W'(1);
  assign off_ext   = PC_W'($signed(i_offset));
  assign stk_full  = (cnt_q == CNT_W'(STK_DEPTH));
  assign stk_empty = (cnt_q == '0);
  assign push_idx  = PTR_W'(cnt_q);
  assign top_idx   = PTR_W'(cnt_q - CNT_W'(1));

`ifdef PC_BREAKPOINT_EN
  logic bp_hit_q, bp_hit_d;
  logic bp_sup_q, bp_sup_d;
  logic bp_match;

  // The matching cycle itself is frozen so the PC parks on the breakpoint address.
  assign bp_match = i_bp_en && (pc_q == i_bp_addr) && !bp_sup_q && !bp_hit_q;
  assign freeze   = i_stall | bp_hit_q | bp_match;

  always_comb begin
    bp_hit_d = bp_hit_q ? ~i_bp_clr : bp_match;
    bp_sup_d = bp_sup_q;
    if (bp_hit_q && i_bp_clr) begin
      bp_sup_d = 1'b1;
    end else if (pc_d != pc_q) begin
      bp_sup_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bp_hit_q <= 1'b0;
      bp_sup_q <= 1'b0;
    end else begin
      bp_hit_q <= bp_hit_d;
      bp_sup_q <= bp_sup_d;
    end
  end

  assign o_bp_hit = bp_hit_q;
`else
  assign freeze = i_stall;
`endif

  always_comb begin
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    push_en = 1'b0;
    // Flag clear is honoured while frozen; a same-cycle error event overrides it.
    ovf_d   = ovf_q & ~i_flag_clr;
    unf_d   = unf_q & ~i_flag_clr;
    if (!freeze) begin
      if (i_ret) begin
        if (stk_empty) begin
          unf_d = 1'b1;
        end else begin
          pc_d  = stk_q[top_idx];
          cnt_d = cnt_q - CNT_W'(1);
        end
      end else if (i_call) begin
        if (stk_full) begin
          ovf_d = 1'b1;
        end else begin
          push_en = 1'b1;
          pc_d    = i_target;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end else if (i_pl) begin
        pc_d = i_target;
      end else if (i_pr) begin
        pc_d = pc_q + off_ext;
      end else if (i_pi) begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q  <= RESET_VEC;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Stack contents need no reset; only the count defines what is valid.
  always_ff @(posedge i_clk) begin
    if (!i_rst && push_en) begin
      stk_q[push_idx] <= pc_inc;
    end
  end

  assign o_pc        = pc_q;
  assign o_stk_cnt   = cnt_q;
  assign o_stk_full  = stk_full;
  assign o_stk_empty = stk_empty;
  assign o_ovf       = ovf_q;
  assign o_unf       = unf_q;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Scoreboard bench for pc_seq_unit (PC_W=8, OFF_W=8, STK_DEPTH=4, RESET_VEC=0), default build.
module tb_pc_seq_unit;

  localparam logic [7:0] C_RST   = 8'h80;
  localparam logic [7:0] C_STALL = 8'h40;
  localparam logic [7:0] C_PI    = 8'h20;
  localparam logic [7:0] C_PL    = 8'h10;
  localparam logic [7:0] C_PR    = 8'h08;
  localparam logic [7:0] C_CALL  = 8'h04;
  localparam logic [7:0] C_RET   = 8'h02;
  localparam logic [7:0] C_FCLR  = 8'h01;

  typedef struct packed {
    logic [7:0] pc;
    logic [2:0] cnt;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       unf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stall = 1'b0, pi = 1'b0, pl = 1'b0, pr = 1'b0;
  logic       call = 1'b0, ret = 1'b0, fclr = 1'b0;
  logic [7:0] target = '0;
  logic [7:0] offset = '0;
  logic [7:0] pc;
  logic [2:0] stk_cnt;
  logic       stk_full, stk_empty, ovf, unf;

  exp_t  exp_q [$];
  string name_q [$];
  int    n_vec = 0;
  int    n_miss = 0;
  bit    stim_done = 1'b0;

  pc_seq_unit #(.PC_W(8), .OFF_W(8), .STK_DEPTH(4), .RESET_VEC(8'h00)) dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_pi(pi), .i_pl(pl), .i_pr(pr),
    .i_call(call), .i_ret(ret), .i_flag_clr(fclr), .i_target(target), .i_offset(offset),
    .o_pc(pc), .o_stk_cnt(stk_cnt), .o_stk_full(stk_full), .o_stk_empty(stk_empty),
    .o_ovf(ovf), .o_unf(unf)
  );

  always #5 clk = ~clk;

  task automatic vec(input logic [7:0] cmd, input logic [7:0] tgt, input logic [7:0] off,
                     input logic [7:0] e_pc, input logic [2:0] e_cnt,
                     input logic e_ovf, input logic e_unf, input string nm);
    exp_t e;
    @(negedge clk);
    {rst, stall, pi, pl, pr, call, ret, fclr} = cmd;
    target = tgt;
    offset = off;
    e.pc    = e_pc;
    e.cnt   = e_cnt;
    e.full  = (e_cnt == 3'd4);
    e.empty = (e_cnt == 3'd0);
    e.ovf   = e_ovf;
    e.unf   = e_unf;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_vec++;
      if ({pc, stk_cnt, stk_full, stk_empty, ovf, unf} !== e) begin
        n_miss++;
        $display("FAIL %s: got pc=%h cnt=%0d full=%b empty=%b ovf=%b unf=%b, want pc=%h cnt=%0d full=%b empty=%b ovf=%b unf=%b",
                 nm, pc, stk_cnt, stk_full, stk_empty, ovf, unf,
                 e.pc, e.cnt, e.full, e.empty, e.ovf, e.unf);
      end
    end
  end

  initial begin
    vec(C_RST, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, "reset");

    for (int i = 0; i < 257; i++)
      vec(C_PI, 8'h00, 8'h00, 8'((i + 1) % 256), 3'd0, 1'b0, 1'b0, "inc_wrap");

    vec(C_PL, 8'h10, 8'h00, 8'h10, 3'd0, 1'b0, 1'b0, "load_10");
    vec(C_PR, 8'h00, 8'hFE, 8'h0E, 3'd0, 1'b0, 1'b0, "rel_minus2");
    vec(C_PR, 8'h00, 8'h05, 8'h13, 3'd0, 1'b0, 1'b0, "rel_plus5");
    vec(C_PL, 8'hFE, 8'h00, 8'hFE, 3'd0, 1'b0, 1'b0, "load_fe");
    vec(C_PR, 8'h00, 8'h03, 8'h01, 3'd0, 1'b0, 1'b0, "rel_wrap");

    vec(C_PL,   8'h20, 8'h00, 8'h20, 3'd0, 1'b0, 1'b0, "load_20");
    vec(C_CALL, 8'h40, 8'h00, 8'h40, 3'd1, 1'b0, 1'b0, "call_40");
    vec(C_CALL, 8'h50, 8'h00, 8'h50, 3'd2, 1'b0, 1'b0, "call_50");
    vec(C_CALL, 8'h60, 8'h00, 8'h60, 3'd3, 1'b0, 1'b0, "call_60");
    vec(C_CALL, 8'h70, 8'h00, 8'h70, 3'd4, 1'b0, 1'b0, "call_70_full");
    vec(C_CALL, 8'h80, 8'h00, 8'h70, 3'd4, 1'b1, 1'b0, "call_overflow");
    vec(C_RET,  8'h00, 8'h00, 8'h61, 3'd3, 1'b1, 1'b0, "ret_61");
    vec(C_RET,  8'h00, 8'h00, 8'h51, 3'd2, 1'b1, 1'b0, "ret_51");
    vec(C_RET,  8'h00, 8'h00, 8'h41, 3'd1, 1'b1, 1'b0, "ret_41");
    vec(C_RET,  8'h00, 8'h00, 8'h21, 3'd0, 1'b1, 1'b0, "ret_21_empty");
    vec(C_FCLR, 8'h00, 8'h00, 8'h21, 3'd0, 1'b0, 1'b0, "clr_ovf");

    vec(C_PL,           8'h33, 8'h00, 8'h33, 3'd0, 1'b0, 1'b0, "load_33");
    vec(C_RET,          8'h00, 8'h00, 8'h33, 3'd0, 1'b0, 1'b1, "ret_underflow");
    vec(C_FCLR,         8'h00, 8'h00, 8'h33, 3'd0, 1'b0, 1'b0, "clr_unf");
    vec(C_RET | C_FCLR, 8'h00, 8'h00, 8'h33, 3'd0, 1'b0, 1'b1, "set_beats_clr");

    vec(C_PL | C_FCLR,  8'h10, 8'h00, 8'h10, 3'd0, 1'b0, 1'b0, "load_10_clr");
    vec(C_CALL,         8'h40, 8'h00, 8'h40, 3'd1, 1'b0, 1'b0, "call_push_11");
    vec(C_CALL | C_RET, 8'h40, 8'h00, 8'h11, 3'd0, 1'b0, 1'b0, "ret_beats_call");
    vec(C_STALL | C_PI, 8'h00, 8'h00, 8'h11, 3'd0, 1'b0, 1'b0, "stall_pi");
    vec(C_STALL | C_RET, 8'h00, 8'h00, 8'h11, 3'd0, 1'b0, 1'b0, "stall_ret_ignored");
    vec(C_RET,          8'h00, 8'h00, 8'h11, 3'd0, 1'b0, 1'b1, "ret_unf_again");
    vec(C_STALL | C_FCLR, 8'h00, 8'h00, 8'h11, 3'd0, 1'b0, 1'b0, "clr_during_stall");
    vec(C_PL | C_PR | C_PI, 8'h80, 8'h05, 8'h80, 3'd0, 1'b0, 1'b0, "pl_beats_pr_pi");
    vec(C_PR | C_PI,    8'h00, 8'h10, 8'h90, 3'd0, 1'b0, 1'b0, "pr_beats_pi");

    vec(C_PL,   8'hFF, 8'h00, 8'hFF, 3'd0, 1'b0, 1'b0, "load_ff");
    vec(C_CALL, 8'h05, 8'h00, 8'h05, 3'd1, 1'b0, 1'b0, "call_from_ff");
    vec(C_RET,  8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, "ret_to_00");

    vec(C_RET,          8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1, "unf_before_rst");
    vec(C_CALL,         8'h30, 8'h00, 8'h30, 3'd1, 1'b0, 1'b1, "push_a");
    vec(C_CALL,         8'h31, 8'h00, 8'h31, 3'd2, 1'b0, 1'b1, "push_b");
    vec(C_RST | C_CALL, 8'h50, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, "rst_beats_call");
    vec(C_RET,          8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1, "stack_empty_after_rst");
    vec(8'h00,          8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1, "hold");

    stim_done = 1'b1;
    @(negedge clk);
    {rst, stall, pi, pl, pr, call, ret, fclr} = 8'h00;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_miss++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
